// File: rtl/execute_alu_issue_pipe_pkg.sv
// Shared encodings for the ALU issue stage: command codes, math/shift/mux
// control encodings and the packed decoded-control bundle carried with each entry.
package execute_alu_issue_pipe_pkg;

  typedef enum logic [4:0] {
    CMD_ADD  = 5'd0,  CMD_SUB  = 5'd1,  CMD_AND  = 5'd2,  CMD_OR   = 5'd3,
    CMD_XOR  = 5'd4,  CMD_ADDI = 5'd5,  CMD_SUBI = 5'd6,  CMD_ANDI = 5'd7,
    CMD_ORI  = 5'd8,  CMD_XORI = 5'd9,  CMD_SLT  = 5'd10, CMD_SLTU = 5'd11,
    CMD_LUI  = 5'd12, CMD_SLL  = 5'd13, CMD_SRL  = 5'd14, CMD_SRA  = 5'd15,
    CMD_SLLV = 5'd16, CMD_SRLV = 5'd17, CMD_SRAV = 5'd18
  } alu_cmd_e;

  typedef enum logic [1:0] {IMM_BYPASS, IMM_SEXT, IMM_ZEXT, IMM_LUI} math_imm_e;
  // FUNC_ZERO0 forces operand A to zero so the immediate passes through (LUI).
  typedef enum logic [2:0] {
    FUNC_ZERO, FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_ZERO0
  } math_func_e;
  typedef enum logic [1:0] {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA} shift_func_e;
  typedef enum logic {SA_RS, SA_IMM} sa_sel_e;
  typedef enum logic [1:0] {MUX_GMATH, MUX_SHIFT, MUX_SLT, MUX_SLTU} alu_mux_e;

  typedef struct packed {
    logic        illegal;
    alu_mux_e    mux;
    shift_func_e shift_func;
    sa_sel_e     sa_sel;
    math_func_e  math_func;
    math_imm_e   math_imm;
  } alu_ctrl_t;

  localparam int CTRL_W = $bits(alu_ctrl_t);

endpackage

// File: rtl/execute_alu_issue_skid.sv
// Generic two-entry valid/ready skid buffer with flush; up_ready comes straight
// from a flop. Held entries are rewritten each cycle from main_hold/skid_hold.
module execute_alu_issue_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [WIDTH-1:0] skid_data,
  input  logic [WIDTH-1:0] main_hold,
  input  logic [WIDTH-1:0] skid_hold
);

  logic main_valid;
  logic skid_empty;
  logic up_fire;
  logic main_free;

  assign up_ready  = skid_empty;
  assign dn_valid  = main_valid;
  assign up_fire   = up_valid & skid_empty;
  assign main_free = !main_valid | dn_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_empty <= 1'b1;
      dn_data    <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_empty <= 1'b1;
    end else if (main_free) begin
      // Skid has priority so ordering stays FIFO; up_fire cannot coincide with it.
      if (!skid_empty) begin
        dn_data    <= skid_hold;
        main_valid <= 1'b1;
        skid_empty <= 1'b1;
      end else if (up_fire) begin
        dn_data    <= up_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else begin
      dn_data <= main_hold;
      if (up_fire) begin
        skid_data  <= up_data;
        skid_empty <= 1'b0;
      end else begin
        skid_data <= skid_hold;
      end
    end
  end

endmodule

// File: rtl/execute_alu_issue_pipe.sv
// Registered ALU issue stage: decodes the ALU command and holds ops in a 2-entry
// skid buffer. Define EXECUTE_ALU_ISSUE_FWD_EN to add writeback operand forwarding.
module execute_alu_issue_pipe
  import execute_alu_issue_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DST_W  = 6,
  parameter int ROB_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_alu_cmd,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  input  logic [15:0]       i_imm,
  input  logic [4:0]        i_shamt,
  input  logic [DST_W-1:0]  i_dst,
  input  logic [ROB_W-1:0]  i_rob,
`ifdef EXECUTE_ALU_ISSUE_FWD_EN
  input  logic              i_wb_valid,
  input  logic [DST_W-1:0]  i_wb_dst,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [DST_W-1:0]  i_rs_tag,
  input  logic [DST_W-1:0]  i_rt_tag,
`endif
  output logic              o_valid,
  input  logic              i_alu_ready,
  output logic [DATA_W-1:0] o_rs,
  output logic [DATA_W-1:0] o_rt,
  output logic [15:0]       o_imm,
  output logic [4:0]        o_shamt,
  output logic [DST_W-1:0]  o_dst,
  output logic [ROB_W-1:0]  o_rob,
  output logic [1:0]        o_alu_math_imm,
  output logic [2:0]        o_alu_math_func,
  output logic              o_alu_shift_sa_sel,
  output logic [1:0]        o_alu_shift_func,
  output logic [1:0]        o_alu_mux,
  output logic              o_illegal
);

  localparam int BASE_W = 2*DATA_W + 16 + 5 + DST_W + ROB_W + CTRL_W;
`ifdef EXECUTE_ALU_ISSUE_FWD_EN
  localparam int PAYLOAD_W = BASE_W + 2*DST_W;
`else
  localparam int PAYLOAD_W = BASE_W;
`endif

  alu_ctrl_t             ctrl;
  alu_ctrl_t             out_ctrl;
  logic [PAYLOAD_W-1:0]  in_data;
  logic [PAYLOAD_W-1:0]  main_q;
  logic [PAYLOAD_W-1:0]  skid_q;
  logic [PAYLOAD_W-1:0]  main_hold;
  logic [PAYLOAD_W-1:0]  skid_hold;

  always_comb begin
    ctrl.illegal    = 1'b0;
    ctrl.mux        = MUX_GMATH;
    ctrl.shift_func = SHIFT_SLL;
    ctrl.sa_sel     = SA_RS;
    ctrl.math_func  = FUNC_ZERO;
    ctrl.math_imm   = IMM_BYPASS;
    case (alu_cmd_e'(i_alu_cmd))
      CMD_ADD:  ctrl.math_func = FUNC_ADD;
      CMD_SUB:  ctrl.math_func = FUNC_SUB;
      CMD_AND:  ctrl.math_func = FUNC_AND;
      CMD_OR:   ctrl.math_func = FUNC_OR;
      CMD_XOR:  ctrl.math_func = FUNC_XOR;
      CMD_ADDI: begin ctrl.math_func = FUNC_ADD; ctrl.math_imm = IMM_SEXT; end
      CMD_SUBI: begin ctrl.math_func = FUNC_SUB; ctrl.math_imm = IMM_SEXT; end
      CMD_ANDI: begin ctrl.math_func = FUNC_AND; ctrl.math_imm = IMM_ZEXT; end
      CMD_ORI:  begin ctrl.math_func = FUNC_OR;  ctrl.math_imm = IMM_ZEXT; end
      CMD_XORI: begin ctrl.math_func = FUNC_XOR; ctrl.math_imm = IMM_ZEXT; end
      CMD_SLT:  begin ctrl.math_func = FUNC_SUB; ctrl.mux = MUX_SLT; end
      CMD_SLTU: begin ctrl.math_func = FUNC_SUB; ctrl.mux = MUX_SLTU; end
      CMD_LUI:  begin ctrl.math_func = FUNC_ZERO0; ctrl.math_imm = IMM_LUI; end
      CMD_SLL:  begin ctrl.shift_func = SHIFT_SLL; ctrl.sa_sel = SA_IMM; ctrl.mux = MUX_SHIFT; end
      CMD_SRL:  begin ctrl.shift_func = SHIFT_SRL; ctrl.sa_sel = SA_IMM; ctrl.mux = MUX_SHIFT; end
      CMD_SRA:  begin ctrl.shift_func = SHIFT_SRA; ctrl.sa_sel = SA_IMM; ctrl.mux = MUX_SHIFT; end
      CMD_SLLV: begin ctrl.shift_func = SHIFT_SLL; ctrl.mux = MUX_SHIFT; end
      CMD_SRLV: begin ctrl.shift_func = SHIFT_SRL; ctrl.mux = MUX_SHIFT; end
      CMD_SRAV: begin ctrl.shift_func = SHIFT_SRA; ctrl.mux = MUX_SHIFT; end
      default:  ctrl.illegal = 1'b1;
    endcase
  end

`ifdef EXECUTE_ALU_ISSUE_FWD_EN
  function automatic logic [DATA_W-1:0] fwd_op(
    input logic [DATA_W-1:0] d, input logic [DST_W-1:0] tag, input logic en,
    input logic wb_valid, input logic [DST_W-1:0] wb_dst, input logic [DATA_W-1:0] wb_data);
    return (en && wb_valid && (tag == wb_dst)) ? wb_data : d;
  endfunction

  // Tags sit above the base payload: rs_tag first, then rt_tag.
  function automatic logic [PAYLOAD_W-1:0] fwd_entry(
    input logic [PAYLOAD_W-1:0] e, input logic en, input logic wb_valid,
    input logic [DST_W-1:0] wb_dst, input logic [DATA_W-1:0] wb_data);
    logic [PAYLOAD_W-1:0] r;
    r = e;
    r[DATA_W-1:0] = fwd_op(e[DATA_W-1:0], e[BASE_W +: DST_W], en, wb_valid, wb_dst, wb_data);
    r[DATA_W +: DATA_W] = fwd_op(e[DATA_W +: DATA_W], e[BASE_W+DST_W +: DST_W], en,
                                 wb_valid, wb_dst, wb_data);
    return r;
  endfunction

  assign in_data   = fwd_entry({i_rt_tag, i_rs_tag, ctrl, i_rob, i_dst, i_shamt, i_imm, i_rt, i_rs},
                               1'b1, i_wb_valid, i_wb_dst, i_wb_data);
  assign main_hold = fwd_entry(main_q, o_valid, i_wb_valid, i_wb_dst, i_wb_data);
  assign skid_hold = fwd_entry(skid_q, !o_ready, i_wb_valid, i_wb_dst, i_wb_data);
`else
  assign in_data   = {ctrl, i_rob, i_dst, i_shamt, i_imm, i_rt, i_rs};
  assign main_hold = main_q;
  assign skid_hold = skid_q;
`endif

  execute_alu_issue_skid #(.WIDTH(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (i_flush),
    .up_valid  (i_valid),
    .up_ready  (o_ready),
    .up_data   (in_data),
    .dn_valid  (o_valid),
    .dn_ready  (i_alu_ready),
    .dn_data   (main_q),
    .skid_data (skid_q),
    .main_hold (main_hold),
    .skid_hold (skid_hold)
  );

  assign {out_ctrl, o_rob, o_dst, o_shamt, o_imm, o_rt, o_rs} = main_q[BASE_W-1:0];
  assign o_illegal          = out_ctrl.illegal;
  assign o_alu_mux          = out_ctrl.mux;
  assign o_alu_shift_func   = out_ctrl.shift_func;
  assign o_alu_shift_sa_sel = out_ctrl.sa_sel;
  assign o_alu_math_func    = out_ctrl.math_func;
  assign o_alu_math_imm     = out_ctrl.math_imm;

endmodule

// File: tb/tb_execute_alu_issue_pipe.sv
// Scoreboard bench for execute_alu_issue_pipe: directed ops with hand-decoded
// expected controls; a negedge monitor pushes on accept and pops on ALU transfer.
module tb_execute_alu_issue_pipe;

  typedef struct {
    logic [4:0]  cmd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [5:0]  dst;
    logic [4:0]  rob;
    logic [1:0]  mimm;
    logic [2:0]  mfunc;
    logic        sa;
    logic [1:0]  shf;
    logic [1:0]  mux;
    logic        ill;
  } op_t;

  logic clk = 1'b0;
  logic reset, i_flush, i_valid, o_ready, i_alu_ready, o_valid;
  logic [4:0]  i_alu_cmd, i_shamt, o_shamt, i_rob, o_rob;
  logic [31:0] i_rs, i_rt, o_rs, o_rt;
  logic [15:0] i_imm, o_imm;
  logic [5:0]  i_dst, o_dst;
  logic [1:0]  o_alu_math_imm, o_alu_shift_func, o_alu_mux;
  logic [2:0]  o_alu_math_func;
  logic        o_alu_shift_sa_sel, o_illegal;
`ifdef EXECUTE_ALU_ISSUE_FWD_EN
  logic        i_wb_valid;
  logic [5:0]  i_wb_dst, i_rs_tag, i_rt_tag;
  logic [31:0] i_wb_data;
`endif

  int checks = 0;
  int errors = 0;
  int seen   = 0;
  op_t cur;
  op_t sb[$];

  always #5 clk = ~clk;

  execute_alu_issue_pipe #(.DATA_W(32), .DST_W(6), .ROB_W(5)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_cmd(i_alu_cmd), .i_rs(i_rs), .i_rt(i_rt), .i_imm(i_imm), .i_shamt(i_shamt),
    .i_dst(i_dst), .i_rob(i_rob),
`ifdef EXECUTE_ALU_ISSUE_FWD_EN
    .i_wb_valid(i_wb_valid), .i_wb_dst(i_wb_dst), .i_wb_data(i_wb_data),
    .i_rs_tag(i_rs_tag), .i_rt_tag(i_rt_tag),
`endif
    .o_valid(o_valid), .i_alu_ready(i_alu_ready), .o_rs(o_rs), .o_rt(o_rt), .o_imm(o_imm),
    .o_shamt(o_shamt), .o_dst(o_dst), .o_rob(o_rob), .o_alu_math_imm(o_alu_math_imm),
    .o_alu_math_func(o_alu_math_func), .o_alu_shift_sa_sel(o_alu_shift_sa_sel),
    .o_alu_shift_func(o_alu_shift_func), .o_alu_mux(o_alu_mux), .o_illegal(o_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Encodings: imm BYPASS0 SEXT1 ZEXT2 LUI3; func ZERO0 ADD1 SUB2 ... ;
  // sa RS0 IMM1; shift SLL0 SRL1 SRA2; mux GMATH0 SHIFT1 SLT2 SLTU3.
  function automatic op_t mk(input logic [4:0] cmd, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [15:0] imm, input logic [5:0] dst, input logic [4:0] rob,
                             input logic [1:0] mimm, input logic [2:0] mfunc, input logic sa,
                             input logic [1:0] shf, input logic [1:0] mux, input logic ill);
    op_t o;
    o.cmd = cmd; o.rs = rs; o.rt = rt; o.imm = imm; o.shamt = rob ^ 5'h0A;
    o.dst = dst; o.rob = rob; o.mimm = mimm; o.mfunc = mfunc; o.sa = sa;
    o.shf = shf; o.mux = mux; o.ill = ill;
    return o;
  endfunction

  always @(negedge clk) begin
    if (reset || i_flush) begin
      sb.delete();
    end else begin
      if (o_valid && i_alu_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_op_dst", 32'(o_dst), 32'hFFFF_FFFF);
        end else begin
          op_t e;
          e = sb.pop_front();
          seen++;
          check($sformatf("rs_cmd%0d", e.cmd), o_rs, e.rs);
          check($sformatf("rt_cmd%0d", e.cmd), o_rt, e.rt);
          check($sformatf("imm_cmd%0d", e.cmd), 32'(o_imm), 32'(e.imm));
          check($sformatf("shamt_cmd%0d", e.cmd), 32'(o_shamt), 32'(e.shamt));
          check($sformatf("dst_cmd%0d", e.cmd), 32'(o_dst), 32'(e.dst));
          check($sformatf("rob_cmd%0d", e.cmd), 32'(o_rob), 32'(e.rob));
          check($sformatf("math_imm_cmd%0d", e.cmd), 32'(o_alu_math_imm), 32'(e.mimm));
          check($sformatf("math_func_cmd%0d", e.cmd), 32'(o_alu_math_func), 32'(e.mfunc));
          check($sformatf("sa_sel_cmd%0d", e.cmd), 32'(o_alu_shift_sa_sel), 32'(e.sa));
          check($sformatf("shift_func_cmd%0d", e.cmd), 32'(o_alu_shift_func), 32'(e.shf));
          check($sformatf("mux_cmd%0d", e.cmd), 32'(o_alu_mux), 32'(e.mux));
          check($sformatf("illegal_cmd%0d", e.cmd), 32'(o_illegal), 32'(e.ill));
        end
      end
      if (i_valid && o_ready) sb.push_back(cur);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o);
    cur = o;
    i_alu_cmd = o.cmd; i_rs = o.rs; i_rt = o.rt; i_imm = o.imm;
    i_shamt = o.shamt; i_dst = o.dst; i_rob = o.rob;
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    i_valid = 1'b1;
    while (!o_ready && n < 50) begin
      tick();
      n++;
    end
    if (!o_ready) check({name, "_accept_timeout"}, 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic send(input op_t o, input string name);
    drive(o);
    wait_accept(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t op_addi, op_sll, op_srav, op_sltu, op_ill, op_a, op_b, op_c, op_xori;
    op_addi = mk(5'd5,  32'h0000_0010, 32'h0000_0020, 16'hFFFF, 6'd1, 5'd1, 2'd1, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0);
    op_sll  = mk(5'd13, 32'h1111_1111, 32'h0000_0001, 16'h0004, 6'd2, 5'd2, 2'd0, 3'd0, 1'b1, 2'd0, 2'd1, 1'b0);
    op_srav = mk(5'd18, 32'h2222_2222, 32'h8000_0000, 16'h0000, 6'd3, 5'd3, 2'd0, 3'd0, 1'b0, 2'd2, 2'd1, 1'b0);
    op_sltu = mk(5'd11, 32'h3333_3333, 32'hFFFF_FFFF, 16'h1234, 6'd4, 5'd4, 2'd0, 3'd2, 1'b0, 2'd0, 2'd3, 1'b0);
    op_ill  = mk(5'h1F, 32'hDEAD_BEEF, 32'hCAFE_F00D, 16'hA5A5, 6'd45, 5'd29, 2'd0, 3'd0, 1'b0, 2'd0, 2'd0, 1'b1);
    op_a    = mk(5'd0,  32'hAAAA_0001, 32'h0, 16'h0, 6'd10, 5'd10, 2'd0, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0);
    op_b    = mk(5'd2,  32'hAAAA_0002, 32'h0, 16'h0, 6'd11, 5'd11, 2'd0, 3'd3, 1'b0, 2'd0, 2'd0, 1'b0);
    op_c    = mk(5'd0,  32'hAAAA_0003, 32'h0, 16'h0, 6'd12, 5'd12, 2'd0, 3'd1, 1'b0, 2'd0, 2'd0, 1'b0);
    op_xori = mk(5'd9,  32'h5555_0000, 32'h1, 16'h00FF, 6'd20, 5'd20, 2'd2, 3'd5, 1'b0, 2'd0, 2'd0, 1'b0);

    reset = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_alu_ready = 1'b1;
`ifdef EXECUTE_ALU_ISSUE_FWD_EN
    i_wb_valid = 1'b0; i_wb_dst = '0; i_wb_data = '0; i_rs_tag = '0; i_rt_tag = '0;
`endif
    drive(op_a);
    tick();
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    check("rst_o_rs", o_rs, 32'd0);
    check("rst_o_dst", 32'(o_dst), 32'd0);
    check("rst_ctrl", {21'd0, o_illegal, o_alu_mux, o_alu_shift_func, o_alu_shift_sa_sel,
                       o_alu_math_func, o_alu_math_imm}, 32'd0);
    reset = 1'b0;
    tick();

    // Single ADDI, one-cycle latency.
    send(op_addi, "addi");
    check("addi_latency_valid", 32'(o_valid), 32'd1);
    tick();
    check("addi_drained", 32'(o_valid), 32'd0);

    // Back-pressure: two accepted then o_ready drops, order preserved.
    i_alu_ready = 1'b0;
    send(op_sll, "sll");
    send(op_srav, "srav");
    check("full_ready_low", 32'(o_ready), 32'd0);
    drive(op_sltu);
    i_valid = 1'b1;
    tick();
    check("stall_ready_low", 32'(o_ready), 32'd0);
    check("stall_rs_stable", o_rs, op_sll.rs);
    check("stall_valid", 32'(o_valid), 32'd1);
    i_alu_ready = 1'b1;
    wait_accept("sltu");
    repeat (4) tick();

    // Illegal command still forwarded.
    send(op_ill, "illegal");
    repeat (2) tick();

    // Flush with both entries full and a pending input.
    i_alu_ready = 1'b0;
    send(op_a, "flush_a");
    send(op_b, "flush_b");
    drive(op_c);
    i_valid = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_o_valid", 32'(o_valid), 32'd0);
    check("flush_o_ready", 32'(o_ready), 32'd1);
    i_alu_ready = 1'b1;
    repeat (3) tick();

    // Flush discards an input whose handshake fired in the same cycle.
    drive(op_c);
    i_valid = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("flush_in_dropped", 32'(o_valid), 32'd0);
    repeat (2) tick();

    // Asynchronous reset while an op is held.
    i_alu_ready = 1'b0;
    send(op_a, "rst_mid");
    check("rst_mid_held", 32'(o_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", 32'(o_valid), 32'd0);
    check("rst_async_ready", 32'(o_ready), 32'd1);
    tick();
    reset = 1'b0;
    i_alu_ready = 1'b1;
    tick();
    send(op_xori, "post_rst");
    check("post_rst_latency", 32'(o_valid), 32'd1);
    repeat (2) tick();

`ifdef EXECUTE_ALU_ISSUE_FWD_EN
    // Writeback forwarding into a held entry.
    i_alu_ready = 1'b0;
    i_rs_tag = 6'd7;
    i_rt_tag = 6'd3;
    send(op_b, "fwd");
    i_wb_valid = 1'b1;
    i_wb_dst = 6'd7;
    i_wb_data = 32'h1234_5678;
    tick();
    i_wb_valid = 1'b0;
    check("fwd_rs", o_rs, 32'h1234_5678);
    check("fwd_rt", o_rt, op_b.rt);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_alu_ready = 1'b1;
    repeat (2) tick();
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("ops_seen", 32'(seen), 32'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_alu_issue_pipe.md
Name: execute_alu_issue_pipe

Overview:
- Registered issue stage directly upstream of the ALU datapath. Accepts one ALU micro-op per cycle from the dispatch/regread stage over a valid/ready handshake.
- Re-decodes the 5-bit ALU command into math, shift and result-mux controls, and registers those controls together with the operands.
- A two-entry skid buffer absorbs ALU back-pressure without a combinational ready path. A flush input kills everything held.

Parameters:
- DATA_W, 32, operand/result width.
- DST_W, 6, destination physical register tag width.
- ROB_W, 5, reorder-buffer tag width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- i_flush  in  1  pipeline kill; drops all held entries
- i_valid  in  1  upstream micro-op valid
- o_ready  out  1  stage can accept this cycle
- i_alu_cmd  in  5  ALU command code
- i_rs  in  DATA_W  operand A
- i_rt  in  DATA_W  operand B
- i_imm  in  16  immediate
- i_shamt  in  5  shift amount field
- i_dst  in  DST_W  destination tag
- i_rob  in  ROB_W  ROB tag
- o_valid  out  1  micro-op presented to ALU
- i_alu_ready  in  1  ALU accepts this cycle
- o_rs, o_rt  out  DATA_W  registered operands
- o_imm  out  16; o_shamt  out  5; o_dst  out  DST_W; o_rob  out  ROB_W
- o_alu_math_imm  out  2; o_alu_math_func  out  3; o_alu_shift_sa_sel  out  1; o_alu_shift_func  out  2; o_alu_mux  out  2
- o_illegal  out  1  command is not a defined ALU code

Behaviour:
- Reset (async, active-high):
  - o_valid=0 and skid entry invalid.
  - o_ready=1.
  - All data/control outputs 0, except decoded controls, which take the decode defaults: ZERO func, BYPASS imm, SLL, SA_RS, GMATH mux.
  - o_illegal=0.
- Handshake:
  - Input transfer: i_valid & o_ready.
  - Output transfer: o_valid & i_alu_ready.
  - o_ready = !skid_valid, driven straight from a flop; no combinational path from i_alu_ready.
- Decode:
  - Performed combinationally on the input side; results are registered with the entry.
  - Latency input→output is exactly 1 cycle when the stage is empty.
- Decode table (func/imm; shift/sa; mux):
  - ADD/SUB/AND/OR/XOR → matching func, BYPASS.
  - ADDI/SUBI → SEXT. ANDI/ORI/XORI → ZEXT.
  - SLT/SLTU → SUB, BYPASS, mux SLT/SLTU.
  - LUI → ZERO0, IMM_LUI.
  - SLL/SRL/SRA → SA_IMM. SLLV/SRLV/SRAV → SA_RS. All shifts use mux SHIFT.
  - Any other code → defaults with o_illegal=1; the micro-op is still forwarded.
- Main register:
  - Loads on input transfer when empty or when its content is leaving this cycle.
  - Otherwise the accepted op goes to the skid entry.
- Skid entry:
  - Drains into main on the first cycle main is leaving or empty.
  - Ordering is strictly FIFO.
- Full case: main valid, skid valid, i_alu_ready=0 → o_ready=0, and all held state is frozen.
- Simultaneous cases, main valid and skid empty:
  - Input transfer plus output transfer → new op to main; skid stays empty.
  - Input transfer without output transfer → skid loads.
- Flush:
  - i_flush=1 invalidates main and skid at the next edge.
  - The input presented in the flush cycle is discarded, even if the handshake fired.
  - o_valid=0 the following cycle and o_ready=1.
  - Flush overrides every other event.
- Reset mid-operation: all entries dropped immediately (asynchronous); no partial state survives.
- Output data is stable while o_valid & !i_alu_ready.

Optional Feature:
- Macro: EXECUTE_ALU_ISSUE_FWD_EN.
- With the macro defined, these ports are added:
  - i_wb_valid (1), i_wb_dst (DST_W), i_wb_data (DATA_W).
  - i_rs_tag and i_rt_tag (DST_W) per input op, stored with each entry.
- Forwarding in held entries: every cycle, each valid held entry whose stored rs/rt tag equals i_wb_dst while i_wb_valid is set replaces that operand with i_wb_data.
- Forwarding on input: the incoming op is forwarded the same way before it is stored.
- Without the macro: these ports are absent and operands pass unchanged.

Decomposition:
- Shared package/def headers hold:
  - ALU command codes.
  - LUT6OPT func and imm encodings.
  - Shift func and SA select encodings.
  - Mux select encodings.
- The entry payload width is a localparam derived from them.
- Natural sub-module: execute_alu_issue_skid, a generic 2-entry valid/ready skid buffer with flush, parameterised by payload width. The decode stays in the top as an always block.

Test Plan:
- ADDI, imm=0xFFFF, i_alu_ready=1 held → one cycle later o_valid=1, math_func=ADD, math_imm=SEXT, mux=GMATH, o_imm=0xFFFF.
- 3 back-to-back ops (SLL, SRAV, SLTU) with i_alu_ready=0 for 2 cycles → o_ready drops after the 2nd accept. Ops emerge in order: SLL (SA_IMM, SHIFT), SRAV (SRA, SA_RS), SLTU (SUB, mux SLTU).
- Command 5'h1F → o_illegal=1, all decode fields at defaults, op still forwarded with its dst/rob.
- Main and skid both full, i_flush=1 for one cycle with i_valid=1 → next cycle o_valid=0, o_ready=1; none of the 3 ops ever appears.
- Assert reset while o_valid=1 → o_valid falls without a clock edge; after release, the first op appears 1 cycle after acceptance.
- With EXECUTE_ALU_ISSUE_FWD_EN: held op with rs_tag=7 and i_alu_ready=0; pulse i_wb_valid, i_wb_dst=7, i_wb_data=0x12345678 → o_rs=0x12345678 next cycle, o_rt unchanged.
